// File: rtl/b11_core_sched_if.sv
// Request/response bundle between b11_core_sched (slave) and its NREQ requesters (master).
interface b11_core_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [6*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [5:0]        rsp_data;
  logic              rsp_drop;

  modport master (
    output req_valid, req_data,
    input  req_ack, rsp_valid, rsp_id, rsp_data, rsp_drop
  );

  modport slave (
    input  req_valid, req_data,
    output req_ack, rsp_valid, rsp_id, rsp_data, rsp_drop
  );
endinterface

// File: rtl/b11_core_sched.sv
// Round-robin scheduler sharing one b11 scrambler core among NREQ requesters.
// Optional macro B11_CORE_SCHED_PRIO_EN gives requester 0 strict priority.
module b11_core_sched #(
  parameter int NREQ     = 4,
  parameter int WAIT_CYC = 12,
  parameter int INIT_CYC = 2
) (
  input  logic            clock,
  input  logic            reset,
  b11_core_sched_if.slave bus,
  output logic            busy,
  output logic [5:0]      core_x_in,
  output logic            core_stbi,
  input  logic [5:0]      core_x_out
);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  localparam logic [4:0] INIT_LAST = 5'(INIT_CYC - 1);
  localparam logic [4:0] WAIT_LAST = 5'(WAIT_CYC - 1);
  localparam logic [2:0] PTR_LAST  = 3'(NREQ - 1);

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [2:0]      gnt_q, gnt_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [2:0]      rsp_id_q, rsp_id_d;
  logic [5:0]      rsp_data_q, rsp_data_d;
  logic            rsp_drop_q, rsp_drop_d;
  logic            busy_q, busy_d;
  logic [5:0]      core_x_in_q, core_x_in_d;
  logic            core_stbi_q, core_stbi_d;

  logic [NREQ-1:0] rot_valid;
  logic            found;
  logic [3:0]      pick_sum;
  logic [2:0]      pick;
  logic [5:0]      pick_word;
  logic            pick_drop;

  // Rotate the request vector so bit 0 is the requester at rr_ptr, then take the first set bit.
  always_comb begin
    rot_valid = NREQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);
    found     = 1'b0;
    pick_sum  = '0;
    pick      = '0;
`ifdef B11_CORE_SCHED_PRIO_EN
    if (bus.req_valid[0]) begin
      found = 1'b1;
    end
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot_valid[i]) begin
        found    = 1'b1;
        pick_sum = 4'(rr_ptr_q) + 4'(i);
        if (pick_sum > 4'(PTR_LAST)) pick_sum = pick_sum - 4'(NREQ);
        pick = pick_sum[2:0];
      end
    end
    pick_word = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (pick == 3'(j)) pick_word = bus.req_data[6*j +: 6];
    end
    pick_drop = (pick_word >= 6'd27) && (pick_word <= 6'd62);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    req_ack_d   = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_drop_d  = rsp_drop_q;
    core_x_in_d = core_x_in_q;
    unique case (state_q)
      S_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_IDLE: begin
        if (found) begin
          gnt_d     = pick;
          req_ack_d = NREQ'(1) << pick;
`ifdef B11_CORE_SCHED_PRIO_EN
          if (pick != 3'd0) rr_ptr_d = (pick == PTR_LAST) ? 3'd0 : pick + 3'd1;
`else
          rr_ptr_d = (pick == PTR_LAST) ? 3'd0 : pick + 3'd1;
`endif
          // Words the core would discard never reach it.
          if (pick_drop) begin
            state_d    = S_RESP;
            rsp_drop_d = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d     = S_LAUNCH;
            core_x_in_d = pick_word;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d    = S_RESP;
          rsp_data_d = core_x_out;
          rsp_drop_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_RESP: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_id_d    = gnt_q;
      end
      default: state_d = S_INIT;
    endcase
    busy_d      = (state_d != S_IDLE);
    core_stbi_d = (state_d != S_LAUNCH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      req_ack_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_drop_q  <= 1'b0;
      busy_q      <= 1'b1;
      core_x_in_q <= '0;
      core_stbi_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      req_ack_q   <= req_ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_drop_q  <= rsp_drop_d;
      busy_q      <= busy_d;
      core_x_in_q <= core_x_in_d;
      core_stbi_q <= core_stbi_d;
    end
  end

  always_ff @(posedge clock) begin
    gnt_q <= gnt_d;
  end

  assign bus.req_ack   = req_ack_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_drop  = rsp_drop_q;
  assign busy          = busy_q;
  assign core_x_in     = core_x_in_q;
  assign core_stbi     = core_stbi_q;
endmodule

// File: tb/tb_b11_core_sched.sv
// Self-checking bench for b11_core_sched with a behavioural stand-in for the b11 core.
`timescale 1ns/1ps
module tb_b11_core_sched;
  localparam int NREQ     = 4;
  localparam int WAIT_CYC = 12;
  localparam int INIT_CYC = 2;
  localparam int DW       = 6 * NREQ;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic       core_stbi;
  logic [5:0] core_x_in;
  logic [5:0] core_x_out;

  int errors = 0;
  int checks = 0;
  int ref_cont = 0;

  b11_core_sched_if #(.NREQ(NREQ)) bus ();

  b11_core_sched #(.NREQ(NREQ), .WAIT_CYC(WAIT_CYC), .INIT_CYC(INIT_CYC)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .core_x_in  (core_x_in),
    .core_stbi  (core_stbi),
    .core_x_out (core_x_out)
  );

  always #5 clock = ~clock;

  // Core stand-in: samples x_in on a stbi-low edge, shows junk while computing,
  // presents the result 8 edges later. 0/63 bump an internal counter (wraps after 25).
  int         core_cont = 0;
  int         core_delay = 0;
  int         core_viol = 0;
  logic [5:0] core_res = '0;

  function automatic logic [5:0] core_fn(input logic [5:0] w, input int cont);
    if (w == 6'd0 || w == 6'd63) return w;
    return 6'((int'(w) + 32 + 2 * cont) % 64);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      core_cont  <= 0;
      core_delay <= 0;
      core_x_out <= '0;
    end else if (!core_stbi) begin
      if (core_delay > 0 || (core_x_in >= 6'd27 && core_x_in <= 6'd62)) core_viol <= core_viol + 1;
      core_delay <= 8;
      core_res   <= core_fn(core_x_in, core_cont);
      core_x_out <= ~core_fn(core_x_in, core_cont);
      if (core_x_in == 6'd0 || core_x_in == 6'd63) core_cont <= (core_cont == 25) ? 0 : core_cont + 1;
    end else if (core_delay > 0) begin
      core_delay <= core_delay - 1;
      if (core_delay == 1) core_x_out <= core_res;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: expected result of one granted word, from the scrambling rules.
  task automatic ref_eval(input logic [5:0] w, output logic [5:0] d, output bit drop);
    drop = (w >= 6'd27 && w <= 6'd62);
    if (drop) begin
      d = 6'd0;
    end else if (w == 6'd0 || w == 6'd63) begin
      d = w;
      ref_cont = (ref_cont + 1) % 26;
    end else begin
      d = 6'((int'(w) + 32 + 2 * ref_cont) % 64);
    end
  endtask

  function automatic logic [5:0] rand_word();
    logic [5:0] edge_w [5];
    edge_w = '{6'd0, 6'd26, 6'd27, 6'd62, 6'd63};
    if ($urandom_range(0, 3) == 0) return edge_w[$urandom_range(0, 4)];
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic post(input int id, input logic [5:0] w);
    bus.req_data  = (bus.req_data & ~(DW'(63) << (6 * id))) | (DW'(w) << (6 * id));
    bus.req_valid = bus.req_valid | (NREQ'(1) << id);
  endtask

  task automatic unpost(input int id);
    bus.req_valid = bus.req_valid & ~(NREQ'(1) << id);
  endtask

  task automatic do_reset(input int cycles);
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (cycles) step();
    reset    = 1'b0;
    ref_cont = 0;
  endtask

  task automatic wait_ack(input int limit, output int id, output bit ok);
    ok = 1'b0;
    id = -1;
    for (int n = 0; n < limit; n++) begin
      step();
      if (bus.req_ack != '0) begin
        for (int i = 0; i < NREQ; i++) if (((bus.req_ack >> i) & 1) != 0) id = i;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_rsp(input int limit, output int lat, output bit ok);
    ok  = 1'b0;
    lat = -1;
    for (int n = 1; n <= limit; n++) begin
      step();
      if (bus.rsp_valid === 1'b1) begin
        lat = n;
        ok  = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] got [8];
    logic [7:0] exp [8];
    string      nm  [8];
    int         n;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (3) step();
    got = '{8'(bus.req_ack), 8'(bus.rsp_valid), 8'(bus.rsp_id), 8'(bus.rsp_data),
            8'(bus.rsp_drop), 8'(busy), 8'(core_x_in), 8'(core_stbi)};
    exp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1};
    nm  = '{"req_ack", "rsp_valid", "rsp_id", "rsp_data", "rsp_drop", "busy", "core_x_in", "core_stbi"};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL reset_%s: got %0h expected %0h", nm[i], got[i], exp[i]);
      end
    end
    reset = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n !== INIT_CYC) begin
      errors++;
      $display("FAIL init_cycles: busy dropped after %0d cycles expected %0d", n, INIT_CYC);
    end
  endtask

  typedef struct {
    bit         fresh;
    int         id;
    logic [5:0] w;
    logic [5:0] exp;
  } launch_t;

  task automatic test_launch();
    launch_t tbl [5];
    int      id, lat;
    bit      ok;
    tbl = '{'{1'b1, 0, 6'd0, 6'd0}, '{1'b1, 1, 6'd0, 6'd0}, '{1'b0, 1, 6'd5, 6'd39},
            '{1'b1, 2, 6'd5, 6'd37}, '{1'b0, 3, 6'd63, 6'd63}};
    foreach (tbl[k]) begin
      if (tbl[k].fresh) do_reset(2);
      post(tbl[k].id, tbl[k].w);
      wait_ack(INIT_CYC + 10, id, ok);
      unpost(tbl[k].id);
      checks++;
      if (!ok || id !== tbl[k].id) begin
        errors++;
        $display("FAIL launch_ack[%0d]: got id %0d expected %0d", k, id, tbl[k].id);
      end
      if (!ok) return;
      checks++;
      if (core_stbi !== 1'b0 || core_x_in !== tbl[k].w) begin
        errors++;
        $display("FAIL launch_core[%0d]: got stbi %0b x_in %0d expected stbi 0 x_in %0d",
                 k, core_stbi, core_x_in, tbl[k].w);
      end
      wait_rsp(WAIT_CYC + 10, lat, ok);
      checks++;
      if (!ok || lat !== WAIT_CYC + 2) begin
        errors++;
        $display("FAIL launch_latency[%0d]: got %0d expected %0d", k, lat, WAIT_CYC + 2);
      end
      if (!ok) return;
      checks++;
      if (bus.rsp_id !== 3'(tbl[k].id) || bus.rsp_data !== tbl[k].exp || bus.rsp_drop !== 1'b0) begin
        errors++;
        $display("FAIL launch_rsp[%0d]: got id %0d data %0d drop %0b expected id %0d data %0d drop 0",
                 k, bus.rsp_id, bus.rsp_data, bus.rsp_drop, tbl[k].id, tbl[k].exp);
      end
      step();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL launch_pulse[%0d]: rsp_valid got %0b expected 0", k, bus.rsp_valid);
      end
    end
  endtask

  task automatic test_drop();
    logic [5:0] words [3];
    int         id, lat, viol0;
    bit         ok;
    words = '{6'd40, 6'd27, 6'd62};
    do_reset(2);
    viol0 = core_viol;
    foreach (words[k]) begin
      post(0, words[k]);
      wait_ack(INIT_CYC + 10, id, ok);
      unpost(0);
      checks++;
      if (!ok || id !== 0 || core_stbi !== 1'b1) begin
        errors++;
        $display("FAIL drop_ack[%0d]: got id %0d stbi %0b expected id 0 stbi 1", k, id, core_stbi);
      end
      if (!ok) return;
      wait_rsp(WAIT_CYC + 10, lat, ok);
      checks++;
      if (!ok || lat !== 1 || bus.rsp_drop !== 1'b1 || bus.rsp_data !== 6'd0 || core_stbi !== 1'b1) begin
        errors++;
        $display("FAIL drop_rsp[%0d]: got lat %0d drop %0b data %0d stbi %0b expected lat 1 drop 1 data 0 stbi 1",
                 k, lat, bus.rsp_drop, bus.rsp_data, core_stbi);
      end
    end
    checks++;
    if (core_viol !== viol0) begin
      errors++;
      $display("FAIL drop_core_untouched: core events got %0d expected %0d", core_viol, viol0);
    end
  endtask

  task automatic test_round_robin();
    int         exp_seq [$];
    logic [5:0] wd [NREQ];
    logic [5:0] exp_d;
    bit         exp_drop, ok;
    int         id, lat;
`ifdef B11_CORE_SCHED_PRIO_EN
    exp_seq = '{0, 0, 0, 1, 2, 3};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    do_reset(2);
    for (int i = 0; i < NREQ; i++) begin
      wd[i] = rand_word();
      post(i, wd[i]);
    end
    foreach (exp_seq[n]) begin
      wait_ack(WAIT_CYC + 10, id, ok);
      checks++;
      if (!ok || id !== exp_seq[n]) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got id %0d expected %0d", n, id, exp_seq[n]);
      end
      if (!ok) return;
      ref_eval(wd[exp_seq[n]], exp_d, exp_drop);
`ifdef B11_CORE_SCHED_PRIO_EN
      if (n == 2) unpost(0);
      else begin
        wd[id] = rand_word();
        post(id, wd[id]);
      end
`else
      wd[id] = rand_word();
      post(id, wd[id]);
`endif
      wait_rsp(WAIT_CYC + 10, lat, ok);
      checks++;
      if (!ok || bus.rsp_id !== 3'(exp_seq[n]) || bus.rsp_data !== exp_d || bus.rsp_drop !== exp_drop) begin
        errors++;
        $display("FAIL rr_rsp[%0d]: got id %0d data %0d drop %0b expected id %0d data %0d drop %0b",
                 n, bus.rsp_id, bus.rsp_data, bus.rsp_drop, exp_seq[n], exp_d, exp_drop);
      end
      if (!ok) return;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid();
    int id, lat, n;
    bit ok;
    do_reset(2);
    post(0, 6'd7);
    wait_ack(INIT_CYC + 10, id, ok);
    unpost(0);
    repeat (5) step();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b1 || core_stbi !== 1'b1) begin
        errors++;
        $display("FAIL midreset[%0d]: got rsp_valid %0b busy %0b stbi %0b expected 0 1 1",
                 c, bus.rsp_valid, busy, core_stbi);
      end
    end
    reset    = 1'b0;
    ref_cont = 0;
    post(2, 6'd5);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      step();
      n++;
      if (bus.rsp_valid === 1'b1) begin
        errors++;
        checks++;
        $display("FAIL midreset_stale: got rsp_valid 1 expected 0");
      end
      if (bus.req_ack != '0) ok = 1'b1;
    end
    unpost(2);
    checks++;
    if (!ok || n !== INIT_CYC + 1 || bus.req_ack !== NREQ'(4)) begin
      errors++;
      $display("FAIL midreset_regrant: got ack %0h after %0d cycles expected 4 after %0d",
               bus.req_ack, n, INIT_CYC + 1);
    end
    wait_rsp(WAIT_CYC + 10, lat, ok);
    checks++;
    if (!ok || lat !== WAIT_CYC + 2 || bus.rsp_id !== 3'd2 || bus.rsp_data !== 6'd37) begin
      errors++;
      $display("FAIL midreset_rsp: got lat %0d id %0d data %0d expected lat %0d id 2 data 37",
               lat, bus.rsp_id, bus.rsp_data, WAIT_CYC + 2);
    end
  endtask

  task automatic test_random();
    bit         pend [NREQ];
    logic [5:0] wd [NREQ];
    logic [5:0] exp_d;
    bit         exp_drop, ok, any;
    int         ptr, g, exp_g, lat, c, p;
    do_reset(2);
    ptr = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = ($urandom_range(0, 1) == 1);
      wd[i]   = rand_word();
      if (pend[i]) post(i, wd[i]);
    end
    if (!pend[1]) begin
      pend[1] = 1'b1;
      post(1, wd[1]);
    end
    for (int t = 0; t < 40; t++) begin
      exp_g = -1;
`ifdef B11_CORE_SCHED_PRIO_EN
      if (pend[0]) exp_g = 0;
`endif
      for (int k = 0; k < NREQ; k++) begin
        c = (ptr + k) % NREQ;
        if (exp_g < 0 && pend[c]) exp_g = c;
      end
      wait_ack(INIT_CYC + WAIT_CYC + 10, g, ok);
      checks++;
      if (!ok || g !== exp_g) begin
        errors++;
        $display("FAIL rand_grant[%0d]: got id %0d expected %0d", t, g, exp_g);
      end
      if (!ok || g < 0) return;
      unpost(g);
      pend[g] = 1'b0;
`ifdef B11_CORE_SCHED_PRIO_EN
      if (exp_g != 0) ptr = (exp_g + 1) % NREQ;
`else
      ptr = (exp_g + 1) % NREQ;
`endif
      ref_eval(wd[exp_g], exp_d, exp_drop);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          wd[i]   = rand_word();
          pend[i] = 1'b1;
          post(i, wd[i]);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(0, NREQ - 1);
        if (pend[p]) begin
          pend[p] = 1'b0;
          unpost(p);
        end
      end
      any = 1'b0;
      for (int i = 0; i < NREQ; i++) if (pend[i]) any = 1'b1;
      if (!any) begin
        p       = $urandom_range(0, NREQ - 1);
        wd[p]   = rand_word();
        pend[p] = 1'b1;
        post(p, wd[p]);
      end
      wait_rsp(WAIT_CYC + 10, lat, ok);
      checks++;
      if (!ok || lat !== (exp_drop ? 1 : WAIT_CYC + 2) || bus.rsp_id !== 3'(exp_g) ||
          bus.rsp_data !== exp_d || bus.rsp_drop !== exp_drop) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: got lat %0d id %0d data %0d drop %0b expected lat %0d id %0d data %0d drop %0b",
                 t, lat, bus.rsp_id, bus.rsp_data, bus.rsp_drop, exp_drop ? 1 : WAIT_CYC + 2,
                 exp_g, exp_d, exp_drop);
      end
      if (!ok) return;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_core_protocol();
    checks++;
    if (core_viol !== 0) begin
      errors++;
      $display("FAIL core_protocol: bad launches got %0d expected 0", core_viol);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    test_reset();
    test_launch();
    test_drop();
    test_round_robin();
    test_reset_mid();
    test_random();
    test_core_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
